// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution engine sequencer.
// Holds the sequencer state encoding, the default size/address parameters
// and the kernel/padding geometry that sets the window scan range.
package conv_pkg;

    localparam int MAX_N_DEF  = 16;  // largest supported matrix side
    localparam int ADDR_W_DEF = 8;   // buffer address width, MAX_N^2 <= 2^ADDR_W
    localparam int KERNEL     = 3;   // window side
    localparam int PAD        = 1;   // zero border added on each side

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PAD  = 3'd2,
        S_SCAN = 3'd3,
        S_FIN  = 3'd4
    } conv_state_t;

endpackage

// File: rtl/conv_idx_counter.sv
// Raster row/col counter: col runs 0..limit-1, then wraps and bumps row.
// Latency: registered, new position visible the cycle after inc.
// Backpressure: advances only when inc is high; clr/rst return to (0,0).
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (advance),
//        limit (side length), row/col (current position),
//        last (position is (limit-1, limit-1)).
module conv_idx_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         last
);

    logic [W-1:0] lim_m1;

    assign lim_m1 = limit - W'(1);
    assign last   = (row == lim_m1) && (col == lim_m1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col == lim_m1) begin
                col <= '0;
                row <= (row == lim_m1) ? '0 : row + W'(1);
            end else begin
                col <= col + W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution job sequencer: size latch, raster buffer load, padding kick-off, 3x3 window scan.
// Latency: all outputs registered (1 cycle) except pix_ready, which is decoded from state.
// Backpressure: pixels accepted on pix_valid in LOAD; window coordinates hold until win_ready.
// Ports: clk, rst (sync, active-high); start/size_in (job request);
//        pix_in/pix_valid/pix_ready (pixel stream); buf_wr_en/addr/data (buffer write);
//        pad_start/pad_done (padding stage); win_valid/win_row/win_col/win_ready (window out);
//        busy, done, err (status).
// Build option: define CONV_SEQ_ABORT_EN to add the abort input, which drops any
// running job back to IDLE with an err pulse.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int MAX_N  = MAX_N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        size_in,
    input  logic [7:0]        pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              pad_start,
    input  logic              pad_done,
    output logic              win_valid,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    input  logic              win_ready,
`ifdef CONV_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic              err
);

    conv_state_t       state, state_d;
    logic [7:0]        n_q;
    logic [7:0]        scan_lim;
    logic [7:0]        ld_row, ld_col;
    logic              ld_last, sc_last;
    logic              abort_w, size_ok, ld_acc, sc_acc, cnt_clr;
    logic [ADDR_W-1:0] ld_addr;

`ifdef CONV_SEQ_ABORT_EN
    assign abort_w = abort && (state != S_IDLE);
`else
    assign abort_w = 1'b0;
`endif

    assign size_ok   = (size_in != 8'd0) && (32'(size_in) <= 32'(MAX_N));
    assign pix_ready = (state == S_LOAD);
    // An abort in the same cycle wins over any handshake completing.
    assign ld_acc    = pix_ready && pix_valid && !abort_w;
    assign sc_acc    = (state == S_SCAN) && win_valid && win_ready && !abort_w;
    assign cnt_clr   = (state == S_IDLE) || abort_w;

    // Window origins over the padded (N+2PAD)^2 matrix that keep a full
    // kernel inside it: N+2PAD-KERNEL+1 positions per side, i.e. N.
    assign scan_lim  = n_q + 8'(2 * PAD) - 8'(KERNEL - 1);
    assign ld_addr   = ADDR_W'(ld_row) * ADDR_W'(n_q) + ADDR_W'(ld_col);

    conv_idx_counter #(.W(8)) u_ld_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (ld_acc),
        .limit (n_q),
        .row   (ld_row),
        .col   (ld_col),
        .last  (ld_last)
    );

    // Scan counter registers drive the window coordinates directly.
    conv_idx_counter #(.W(8)) u_sc_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (sc_acc),
        .limit (scan_lim),
        .row   (win_row),
        .col   (win_col),
        .last  (sc_last)
    );

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start && size_ok)          state_d = S_LOAD;
            S_LOAD: if (ld_acc && ld_last)         state_d = S_PAD;
            // pad_start marks the first PAD cycle; a pad_done then is stale.
            S_PAD:  if (pad_done && !pad_start)    state_d = S_SCAN;
            S_SCAN: if (sc_acc && sc_last)         state_d = S_FIN;
            S_FIN:                                 state_d = S_IDLE;
            default:                               state_d = S_IDLE;
        endcase
        if (abort_w) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            n_q         <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            pad_start   <= 1'b0;
            win_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && start) n_q <= size_in;
            buf_wr_en <= ld_acc;
            if (ld_acc) begin
                buf_wr_addr <= ld_addr;
                buf_wr_data <= pix_in;
            end
            pad_start <= ld_acc && ld_last;
            win_valid <= (state_d == S_SCAN);
            busy      <= (state_d != S_IDLE);
            done      <= sc_acc && sc_last;
            err       <= (state == S_IDLE && start && !size_ok) || abort_w;
        end
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Top-level controller for the convolution engine. Latches the matrix size, accepts an N×N matrix byte-by-byte into the input buffer, triggers the padding stage, then scans every 3×3 window position of the padded matrix and hands window coordinates to the MAC datapath over a valid/ready handshake. It is the one block that sequences the buffer and padding stages.

## Interface

- `MAX_N`, default 16: largest supported matrix side.
- `ADDR_W`, default 8: buffer address width. Must satisfy MAX_N² ≤ 2^ADDR_W.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: begin a job. Sampled only in IDLE.
- `size_in` input 8: matrix side N, sampled with `start`.
- `pix_in` input 8: matrix element.
- `pix_valid` input 1: `pix_in` is valid.
- `pix_ready` output 1: sequencer accepts a pixel this cycle.
- `buf_wr_en` output 1: buffer write strobe.
- `buf_wr_addr` output ADDR_W: buffer write address, row*N+col.
- `buf_wr_data` output 8: buffer write data.
- `pad_start` output 1: one-cycle pulse that starts the padding stage.
- `pad_done` input 1: padding stage finished.
- `win_valid` output 1: window coordinates are valid.
- `win_row`, `win_col` output 8 each: top-left corner of the window in padded coordinates.
- `win_ready` input 1: datapath accepts the window.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the job completes.
- `err` output 1: one-cycle pulse when a size is rejected.

## Operation

- States are IDLE, LOAD, PAD, SCAN and FIN.
- **IDLE**
  - On `start`, the block latches N.
  - If N is 0 or N > MAX_N, it pulses `err` on the next cycle and stays in IDLE.
  - Otherwise it goes to LOAD.
- **LOAD**
  - `pix_ready` = 1.
  - Each cycle with `pix_valid` && `pix_ready` writes `pix_in` to addresses 0,1,…,N²−1 in raster order.
  - After the N²-th accepted pixel, the block goes to PAD.
- **PAD**
  - `pad_start` pulses high in the first PAD cycle only.
  - The block then waits for `pad_done`.
  - `pad_done` is ignored in the cycle `pad_start` is high.
  - When `pad_done` is seen, the block goes to SCAN.
- **SCAN**
  - Window origins run raster-order over (row,col) ∈ [0,N−1]² of the (N+2)×(N+2) padded matrix, which gives same-size output.
  - `win_valid` stays high. `win_row`/`win_col` hold stable until `win_valid` && `win_ready`, then advance.
  - Column wraps N−1→0 and increments row.
  - Acceptance of (N−1,N−1) moves the block to FIN.
- **FIN**
  - `done` = 1 for one cycle, then the block returns to IDLE.
- **Start handling:** `start` outside IDLE is ignored. It is not queued.
- **Pixels outside LOAD:** ignored (`pix_ready` = 0).
- **Reset values:** every output 0; state IDLE; counters 0. Reset in any state, mid-job included, abandons the job with no `done`.

## Timing

- `start` at cycle t gives LOAD (`pix_ready`=1, `busy`=1) at t+1. A bad size gives `err` at t+1.
- A pixel accepted at t gives `buf_wr_en`/`addr`/`data` at t+1, registered, 1-cycle latency.
- The last pixel accepted at t gives `pad_start` at t+1.
- `pad_done` at t gives `win_valid` at t+1 with (0,0).
- With `win_ready` held high, there is one window per cycle. Minimum job time is N² + N² + 3 + pad latency cycles.
- The last window accepted at t gives `done` at t+1 and IDLE at t+2. A new `start` is accepted at t+2.
- All outputs are registered. There is no combinational input→output path except `pix_ready`, which is state-decoded.

## Configuration

- `CONV_SEQ_ABORT_EN`: adds input `abort` (1 bit).
  - `abort` high in any non-IDLE state forces IDLE on the next cycle and clears counters.
  - It pulses `err` instead of `done`.
  - `abort` takes priority over all other transitions in that cycle, and is ignored in IDLE.
- Without the macro, the port does not exist and jobs can only be cut short by `rst`.

## Structure

- Package `conv_pkg`:
  - state enum `conv_state_t`
  - `MAX_N` and `ADDR_W` defaults
  - `KERNEL` = 3
  - `PAD` = 1
- Sub-module `conv_idx_counter`: raster row/col counter with increment enable, programmable wrap limit, synchronous clear, and `last` flag. It is instantiated twice, once for the LOAD write address and once for SCAN coordinates.

## Test plan

- **N=2 normal job:** `start`, pixels 0x11,0x22,0x33,0x44 → writes addr 0..3 with those data; one `pad_start`; `pad_done` → windows (0,0),(0,1),(1,0),(1,1); one `done`.
- **Size rejection:** `size_in`=0, then `size_in`=17 with MAX_N=16 → `err` pulse each time, `busy` stays 0, no buffer writes.
- **Backpressure:** N=3 with `win_ready` low for 4 cycles on window (1,2) → coordinates held stable and `win_valid` stays 1; exactly 9 windows total.
- **Gapped input:** N=3 with `pix_valid` toggling every other cycle → 9 writes with consecutive addresses 0..8; PAD entered only after the 9th write.
- **Reset/start hazards:** `rst` asserted mid-SCAN → all outputs 0 next cycle, no `done`; `start` pulsed during LOAD → ignored, address sequence unchanged.
- **Abort (with `CONV_SEQ_ABORT_EN`):** `abort` during PAD → IDLE next cycle, `err` pulse, no `win_valid`.
